// File: rtl/minmax_search_seq.sv
// minmax_search_seq
// Memory-read sequencer for a vector min/max search. Streams LEN signed
// samples starting at a base address through a running-extreme compare and
// reports the extreme value and the index where it first appears.
//
// Optional build macro: MINMAX_SEARCH_ABS_EN
//   When defined, samples are ranked by magnitude (DATA_W+1 bits wide, so
//   the most negative sample is the largest). result_o still returns the
//   original signed sample. When undefined, a plain signed compare is used
//   and no magnitude logic exists.

module minmax_search_seq #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              rd_req_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic              rd_gnt_i,
    input  logic              rd_valid_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [DATA_W-1:0] result_o,
    output logic [LEN_W-1:0]  index_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;

    // Job parameters captured at start so later input changes are harmless.
    logic              mode_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issue_cnt_q;
    logic [LEN_W-1:0]  beat_cnt_q;

    logic              start_acc;
    logic              grant;
    logic              beat;
    logic              last_grant;
    logic              last_beat;
    logic              cand_gt;
    logic              cand_lt;
    logic              replace;
    logic              load_best;
    logic [LEN_W:0]    issued_incl;

    // ------------------------------------------------------------------
    // Handshake qualification
    // ------------------------------------------------------------------

    // A beat is only taken while a read is outstanding; a grant landing in
    // the same cycle counts as outstanding so a zero-latency memory works.
    always_comb begin
        start_acc   = (state_q == S_IDLE) && start_i;
        grant       = rd_req_o && rd_gnt_i;
        issued_incl = {1'b0, issue_cnt_q} + (LEN_W+1)'(grant);
        beat        = rd_valid_i
                      && ((state_q == S_ISSUE) || (state_q == S_DRAIN))
                      && (issued_incl > {1'b0, beat_cnt_q});
        last_grant  = grant && (issue_cnt_q == len_q - LEN_W'(1));
        last_beat   = beat  && (beat_cnt_q  == len_q - LEN_W'(1));
    end

    // ------------------------------------------------------------------
    // Running-extreme compare
    // ------------------------------------------------------------------

`ifdef MINMAX_SEARCH_ABS_EN
    // Magnitudes need one extra bit so that -2**(DATA_W-1) is representable.
    logic [DATA_W:0]   cand_ext;
    logic [DATA_W:0]   cand_mag;
    logic [DATA_W:0]   best_mag_q;
    logic [DATA_W+1:0] diff;

    // Rank candidates by unsigned magnitude; zero-extend before subtracting.
    always_comb begin
        cand_ext = {rd_data_i[DATA_W-1], rd_data_i};
        cand_mag = rd_data_i[DATA_W-1] ? -cand_ext : cand_ext;
        diff     = {1'b0, cand_mag} - {1'b0, best_mag_q};
        cand_gt  = !diff[DATA_W+1] && (diff != '0);
        cand_lt  = diff[DATA_W+1];
    end

    // Magnitude of the current best, loaded alongside result_o.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            best_mag_q <= '0;
        end else if (start_acc) begin
            best_mag_q <= '0;
        end else if (load_best) begin
            best_mag_q <= cand_mag;
        end
    end
`else
    logic [DATA_W:0]   diff;

    // Sign-extend both operands by one bit so the subtract cannot overflow,
    // which keeps the order right even for the most negative vs most positive.
    always_comb begin
        diff    = {rd_data_i[DATA_W-1], rd_data_i} - {result_o[DATA_W-1], result_o};
        cand_gt = !diff[DATA_W] && (diff != '0);
        cand_lt = diff[DATA_W];
    end
`endif

    // Strict compares keep the earlier index on ties; beat 0 always seeds.
    always_comb begin
        replace   = mode_q ? cand_lt : cand_gt;
        load_best = beat && ((beat_cnt_q == '0) || replace);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state: the final beat wins over the final grant so a same-cycle
    // grant and beat on the last element goes straight to DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) state_d = (len_i == '0) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                if (last_beat)       state_d = S_DONE;
                else if (last_grant) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (last_beat) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded purely from state.
    always_comb begin
        busy_o   = 1'b0;
        rd_req_o = 1'b0;
        done_o   = 1'b0;
        unique case (state_q)
            S_IDLE:  ;
            S_ISSUE: begin busy_o = 1'b1; rd_req_o = 1'b1; end
            S_DRAIN: busy_o = 1'b1;
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Job capture, address/issue/beat counters and result registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mode_q      <= 1'b0;
            len_q       <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            rd_addr_o   <= '0;
            result_o    <= '0;
            index_o     <= '0;
        end else if (start_acc) begin
            mode_q      <= mode_i;
            len_q       <= len_i;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            rd_addr_o   <= base_addr_i;
            result_o    <= '0;
            index_o     <= '0;
        end else begin
            // Address wraps naturally at 2**ADDR_W.
            if (grant) begin
                rd_addr_o   <= rd_addr_o + ADDR_W'(1);
                issue_cnt_q <= issue_cnt_q + LEN_W'(1);
            end
            if (beat) begin
                beat_cnt_q <= beat_cnt_q + LEN_W'(1);
            end
            if (load_best) begin
                result_o <= rd_data_i;
                index_o  <= beat_cnt_q;
            end
        end
    end

endmodule
